noc_credit_link: RTL and testbench
==================================

// Module: noc_credit_link
// PURPOSE
//  Credit-based pipelined link between one router output port and the neighbouring router input port.
//  Retimes flits forward and credits backward over NUM_PIPELINE register stages each.
//  Monitors credit conservation and packet framing at the link input.
//  Instantiated once per mesh direction, between data_out/credit_in of one router and data_in/credit_out of the next.
// PARAMETERS
//  FLIT_WIDTH        64  flit payload width
//  DEST_WIDTH        4   dest field width (TDEST_WIDTH+TID_WIDTH)
//  NUM_PIPELINE      2   register stages per direction; legal 0..8
//  FLIT_BUFFER_DEPTH 8   downstream input-buffer depth = initial credit count
//  CNT_WIDTH         $clog2(FLIT_BUFFER_DEPTH+1)  credit counter width (derived)
// PORTS
//  clk_noc        in   1           NoC clock; the only clock
//  rst_noc        in   1           asynchronous reset, active-high
//  data_in        in   FLIT_WIDTH  flit from upstream router output
//  dest_in        in   DEST_WIDTH  flit destination
//  is_tail_in     in   1           last flit of packet
//  send_in        in   1           flit valid (one flit per cycle max)
//  credit_out     out  1           credit returned to upstream router
//  data_out       out  FLIT_WIDTH  flit to downstream router input
//  dest_out       out  DEST_WIDTH  delayed dest_in
//  is_tail_out    out  1           delayed is_tail_in
//  send_out       out  1           delayed send_in
//  credit_in      in   1           credit from downstream router
//  credits_avail  out  CNT_WIDTH   upstream-view credits remaining
//  in_packet      out  1           1 while a multi-flit packet is open at the input
//  pkt_count      out  16          tails seen at input, saturating
//  err_overflow   out  1           sticky: send_in with credits_avail==0
//  err_underflow  out  1           sticky: credit return with credits_avail==FLIT_BUFFER_DEPTH
// BEHAVIOUR
//  Forward path
//  - {data,dest,is_tail,send} pass through NUM_PIPELINE registers; latency = NUM_PIPELINE cycles.
//  - Registers are unconditional: no enable, no stall. The credit protocol guarantees downstream room.
//  Credit path
//  - credit_in passes through NUM_PIPELINE registers to credit_out.
//  - NUM_PIPELINE=0: both paths are pure wires. The monitor still operates.
//  Reset
//  - All pipeline registers, send_out, is_tail_out, credit_out, data_out, dest_out = 0.
//  - credits_avail=FLIT_BUFFER_DEPTH, in_packet=0, pkt_count=0, err_*=0.
//  - Reset mid-operation discards all in-flight flits and credits. No partial output after release.
//  Credit monitor (updates on clk_noc, observes send_in and credit_out)
//  - send_in & !credit_out: credits_avail -1.
//  - credit_out & !send_in: +1.
//  - Both or neither: unchanged.
//  - send_in & !credit_out at credits_avail==0: err_overflow<=1, counter holds at 0.
//  - credit_out & !send_in at FLIT_BUFFER_DEPTH: err_underflow<=1, counter holds at max.
//  - Errors clear only on rst_noc. The flit is still forwarded; the link never drops data.
//  Packet FSM (states IDLE, BODY; in_packet = state==BODY)
//  - IDLE --send_in & !is_tail_in--> BODY.
//  - BODY --send_in & is_tail_in--> IDLE.
//  - All other cases hold state.
//  - Any send_in & is_tail_in increments pkt_count, including single-flit packets from IDLE.
//  - pkt_count saturates at 16'hFFFF; no wrap.
//  Sequencing
//  - All monitor outputs are registered; they reflect events one cycle after the event.
// TESTING
//  1 NUM_PIPELINE=2: send_in pulse, data_in=64'hDEAD_BEEF, dest_in=4'h5 -> send_out=1 with same data/dest exactly 2 cycles later, for 1 cycle.
//  2 Eight back-to-back flits, credit_in held 0 -> credits_avail 8->0, err_overflow=0. Ninth flit -> err_overflow=1, counter stays 0, flit appears on send_out.
//  3 send_in and credit_out in the same cycle at credits_avail=3 -> stays 3. Extra credit_in at 8 -> err_underflow=1 after NUM_PIPELINE+1 cycles.
//  4 Packets of 3 flits, then 1 flit, then 5 flits -> in_packet high during bodies, pkt_count=3. 65540 tails -> pkt_count=16'hFFFF.
//  5 rst_noc asserted with 2 flits in flight -> send_out=0 immediately (async). After release: no ghost flits, credits_avail=8.
//  6 NUM_PIPELINE=0 -> send_out==send_in and credit_out==credit_in combinationally. Monitor behaves as in scenarios 2-4.

Source files
------------

// File: rtl/noc_credit_link.sv
// noc_credit_link
//   Credit-based pipelined link between two neighbouring routers. Flits travel
//   forward and credits travel backward, each through NUM_PIPELINE register
//   stages. A monitor at the link input tracks the credits left upstream and
//   the packet framing, and flags credit protocol violations.
//
// Ports
//   clk_noc, rst_noc                   clock, async active-high reset
//   data_in/dest_in/is_tail_in/send_in flit from the upstream router
//   data_out/dest_out/is_tail_out/send_out  retimed flit to the downstream router
//   credit_in                          credit from the downstream router
//   credit_out                         retimed credit to the upstream router
//   credits_avail                      credits still held by the upstream router
//   in_packet                          a multi-flit packet is open at the input
//   pkt_count                          tails seen at the input (saturating)
//   err_overflow / err_underflow       sticky credit protocol errors
module noc_credit_link #(
    parameter int FLIT_WIDTH        = 64,
    parameter int DEST_WIDTH        = 4,
    parameter int NUM_PIPELINE      = 2,
    parameter int FLIT_BUFFER_DEPTH = 8,
    parameter int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                  clk_noc,
    input  logic                  rst_noc,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in,
    output logic [CNT_WIDTH-1:0]  credits_avail,
    output logic                  in_packet,
    output logic [15:0]           pkt_count,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
        logic                  send;
    } flit_t;

    typedef enum logic {IDLE, BODY} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(FLIT_BUFFER_DEPTH);

    flit_t flit_d;
    flit_t flit_q;

    assign flit_d = {data_in, dest_in, is_tail_in, send_in};

    // Both directions are free-running shift registers: the credit protocol
    // guarantees the downstream buffer has room, so no stall is ever needed.
    generate
        if (NUM_PIPELINE == 0) begin : g_wire
            assign flit_q     = flit_d;
            assign credit_out = credit_in;
        end else begin : g_pipe
            flit_t                   fwd [NUM_PIPELINE];
            logic [NUM_PIPELINE-1:0] crd;

            always_ff @(posedge clk_noc or posedge rst_noc) begin
                if (rst_noc) begin
                    for (int i = 0; i < NUM_PIPELINE; i++) fwd[i] <= '0;
                    crd <= '0;
                end else begin
                    fwd[0] <= flit_d;
                    crd[0] <= credit_in;
                    for (int i = 1; i < NUM_PIPELINE; i++) begin
                        fwd[i] <= fwd[i-1];
                        crd[i] <= crd[i-1];
                    end
                end
            end

            assign flit_q     = fwd[NUM_PIPELINE-1];
            assign credit_out = crd[NUM_PIPELINE-1];
        end
    endgenerate

    assign data_out    = flit_q.data;
    assign dest_out    = flit_q.dest;
    assign is_tail_out = flit_q.is_tail;
    assign send_out    = flit_q.send;

    // Credit monitor: mirrors the upstream router's counter, which only sees
    // credits once they have crossed the return pipeline (credit_out).
    logic take;
    logic give;

    assign take = send_in & ~credit_out;
    assign give = credit_out & ~send_in;

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            credits_avail <= CNT_MAX;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else if (take) begin
            if (credits_avail == '0) err_overflow <= 1'b1;
            else                     credits_avail <= credits_avail - CNT_WIDTH'(1);
        end else if (give) begin
            if (credits_avail == CNT_MAX) err_underflow <= 1'b1;
            else                          credits_avail <= credits_avail + CNT_WIDTH'(1);
        end
    end

    // Packet framing
    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (send_in && !is_tail_in) state_nxt = BODY;
            BODY:    if (send_in && is_tail_in)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_packet = (state == BODY);

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc)                                           pkt_count <= '0;
        else if (send_in && is_tail_in && pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
    end

endmodule

// File: tb/tb_noc_credit_link.sv
// Bench for noc_credit_link: one instance with NUM_PIPELINE=0 (index 0) and
// one with NUM_PIPELINE=2 (index 1) share the same stimulus. Issued flits are
// queued with their due cycle; a negedge monitor pops them when send_out
// shows up and compares link state against a cycle-level reference model.
module tb_noc_credit_link;

    logic        clk_noc = 1'b0;
    logic        rst_noc;
    logic [63:0] data;
    logic [3:0]  dest;
    logic        tail, send, cin;

    logic [63:0] d_out [2];
    logic [3:0]  ds_out [2];
    logic        t_out [2], s_out [2], c_out [2], inp [2], ov [2], un [2];
    logic [3:0]  cav [2];
    logic [15:0] pc [2];

    noc_credit_link #(.NUM_PIPELINE(0)) u_z (
        .clk_noc(clk_noc), .rst_noc(rst_noc), .data_in(data), .dest_in(dest),
        .is_tail_in(tail), .send_in(send), .credit_out(c_out[0]), .data_out(d_out[0]),
        .dest_out(ds_out[0]), .is_tail_out(t_out[0]), .send_out(s_out[0]),
        .credit_in(cin), .credits_avail(cav[0]), .in_packet(inp[0]), .pkt_count(pc[0]),
        .err_overflow(ov[0]), .err_underflow(un[0]));

    noc_credit_link #(.NUM_PIPELINE(2)) u_p (
        .clk_noc(clk_noc), .rst_noc(rst_noc), .data_in(data), .dest_in(dest),
        .is_tail_in(tail), .send_in(send), .credit_out(c_out[1]), .data_out(d_out[1]),
        .dest_out(ds_out[1]), .is_tail_out(t_out[1]), .send_out(s_out[1]),
        .credit_in(cin), .credits_avail(cav[1]), .in_packet(inp[1]), .pkt_count(pc[1]),
        .err_overflow(ov[1]), .err_underflow(un[1]));

    always #5 clk_noc = ~clk_noc;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  dest;
        logic        tail;
        int          due;
    } exp_t;

    exp_t q [2][$];
    int   n_chk = 0, n_fail = 0, cyc = 0;

    // reference model state
    int m_cr [2];
    bit m_ov [2], m_un [2];
    bit m_inp;
    int m_pc;
    bit cdl [2];                 // credit delay line for the 2-stage link, [1] is oldest

    function automatic int lat(int p);
        return p == 0 ? 0 : 2;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_cr[p] = 8; m_ov[p] = 0; m_un[p] = 0;
            q[p].delete();
        end
        m_inp = 0; m_pc = 0;
        cdl[0] = 0; cdl[1] = 0;
    endtask

    // Advance one clock; the model consumes the inputs the DUT samples at this edge.
    task automatic tick();
        bit co [2];
        @(posedge clk_noc);
        if (!rst_noc) begin
            co[0] = cin;
            co[1] = cdl[1];
            for (int p = 0; p < 2; p++) begin
                if (send && !co[p]) begin
                    if (m_cr[p] == 0) m_ov[p] = 1; else m_cr[p]--;
                end else if (co[p] && !send) begin
                    if (m_cr[p] == 8) m_un[p] = 1; else m_cr[p]++;
                end
            end
            if (send) begin
                m_inp = !tail;
                if (tail && m_pc < 65535) m_pc++;
            end
            cdl[1] = cdl[0];
            cdl[0] = cin;
        end
        cyc++;
        #1;
    endtask

    task automatic drive(logic s, logic t, logic c, logic [63:0] d, logic [3:0] ds);
        send = s; tail = t; cin = c; data = d; dest = ds;
        if (s) for (int p = 0; p < 2; p++) q[p].push_back('{d, ds, t, cyc + lat(p)});
        tick();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 64'h0, 4'h0);
    endtask

    task automatic rflit(logic t, logic c);
        drive(1, t, c, {$urandom, $urandom}, 4'($urandom_range(0, 15)));
    endtask

    // monitor: flits and link state, sampled away from the active edge
    task automatic mon_flit(int p);
        exp_t e;
        if (s_out[p]) begin
            chk($sformatf("ghost%0d", p), 64'(q[p].size() > 0), 64'd1);
            if (q[p].size() > 0) begin
                e = q[p].pop_front();
                chk($sformatf("data%0d", p), d_out[p], e.data);
                chk($sformatf("dest%0d", p), 64'(ds_out[p]), 64'(e.dest));
                chk($sformatf("tail%0d", p), 64'(t_out[p]), 64'(e.tail));
                chk($sformatf("latency%0d", p), 64'(cyc), 64'(e.due));
            end
        end else if (q[p].size() > 0 && q[p][0].due <= cyc) begin
            chk($sformatf("missing%0d", p), 64'(s_out[p]), 64'd1);
            void'(q[p].pop_front());
        end
    endtask

    always @(negedge clk_noc) begin
        for (int p = 0; p < 2; p++) begin
            mon_flit(p);
            chk($sformatf("credits%0d", p), 64'(cav[p]), 64'(m_cr[p]));
            chk($sformatf("ovf%0d", p), 64'(ov[p]), 64'(m_ov[p]));
            chk($sformatf("unf%0d", p), 64'(un[p]), 64'(m_un[p]));
            chk($sformatf("in_packet%0d", p), 64'(inp[p]), 64'(m_inp));
            chk($sformatf("pkt_count%0d", p), 64'(pc[p]), 64'(m_pc));
        end
        chk("credit_wire", 64'(c_out[0]), rst_noc ? 64'd0 : 64'(cin));
        chk("credit_pipe", 64'(c_out[1]), 64'(cdl[1]));
    end

    task automatic reset_mid();
        #2;
        rst_noc = 1'b1;
        model_reset();
        #1;
        chk("rst_send_out", 64'(s_out[1]), 64'd0);
        chk("rst_data_out", d_out[1], 64'd0);
        chk("rst_credits", 64'(cav[1]), 64'd8);
        idle(2);
        rst_noc = 1'b0;
    endtask

    task automatic packet(int n);
        for (int i = 0; i < n; i++) begin
            rflit(i == n - 1, 1'b1);
            if (i < n - 1) chk("pkt_open", 64'(inp[1]), 64'd1);
        end
        chk("pkt_closed", 64'(inp[1]), 64'd0);
    endtask

    initial begin
        rst_noc = 1'b1;
        send = 0; tail = 0; cin = 0; data = '0; dest = '0;
        model_reset();
        idle(2);
        rst_noc = 1'b0;
        chk("reset_credits", 64'(cav[1]), 64'd8);
        chk("reset_pc", 64'(pc[1]), 64'd0);

        // single flit, fixed 2-cycle latency on the pipelined link
        drive(1, 1, 0, 64'hDEAD_BEEF, 4'h5);
        send = 0;
        chk("s1_early", 64'(s_out[1]), 64'd0);
        idle(1);
        chk("s1_send", 64'(s_out[1]), 64'd1);
        chk("s1_data", d_out[1], 64'hDEAD_BEEF);
        chk("s1_dest", 64'(ds_out[1]), 64'h5);
        idle(1);
        chk("s1_one_cycle", 64'(s_out[1]), 64'd0);
        drive(0, 0, 1, 64'h0, 4'h0);
        idle(3);

        // exhaust credits, then overflow
        for (int i = 0; i < 8; i++) rflit(1'b0, 1'b0);
        for (int p = 0; p < 2; p++) begin
            chk("s2_zero", 64'(cav[p]), 64'd0);
            chk("s2_no_ovf", 64'(ov[p]), 64'd0);
        end
        rflit(1'b1, 1'b0);
        for (int p = 0; p < 2; p++) begin
            chk("s2_ovf", 64'(ov[p]), 64'd1);
            chk("s2_hold0", 64'(cav[p]), 64'd0);
        end
        idle(3);

        // reset with flits in flight
        rflit(1'b0, 1'b0);
        rflit(1'b1, 1'b0);
        reset_mid();
        idle(4);
        chk("s5_credits", 64'(cav[1]), 64'd8);

        // simultaneous send and credit at 3
        for (int i = 0; i < 5; i++) rflit(1'b0, 1'b0);
        rflit(1'b1, 1'b1);
        chk("s3_same_cycle", 64'(cav[0]), 64'd3);
        idle(3);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 64'h0, 4'h0);
        idle(3);
        chk("s3_full", 64'(cav[1]), 64'd8);
        drive(0, 0, 1, 64'h0, 4'h0);
        chk("s3_unf_wire", 64'(un[0]), 64'd1);
        chk("s3_unf_p1", 64'(un[1]), 64'd0);
        idle(1);
        chk("s3_unf_p2", 64'(un[1]), 64'd0);
        idle(1);
        chk("s3_unf_p3", 64'(un[1]), 64'd1);
        chk("s3_hold8", 64'(cav[1]), 64'd8);

        // packet framing
        reset_mid();
        packet(3);
        packet(1);
        packet(5);
        idle(3);
        chk("s4_pc3", 64'(pc[1]), 64'd3);

        // randomized traffic
        for (int i = 0; i < 1500; i++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), {$urandom, $urandom}, 4'($urandom_range(0, 15)));
        idle(4);

        // pkt_count saturation
        reset_mid();
        for (int i = 0; i < 65540; i++) drive(1, 1, 1, 64'(i), 4'(i));
        idle(4);
        chk("s4_sat", 64'(pc[1]), 64'hFFFF);
        chk("s4_sat_z", 64'(pc[0]), 64'hFFFF);
        for (int p = 0; p < 2; p++) chk("drain", 64'(q[p].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
